// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_HALT,
        S_RUN
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_MRET,
        SEL_MISALIGN,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
    localparam int          DEF_INC       = 4;
    localparam int          DEF_CNT_W     = 32;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority selection for the PC generator.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
    parameter int              INC      = DEF_INC
) (
    input  logic            i_run,
    input  logic            i_halted,
    input  logic            i_stall,
    input  logic            i_trap,
    input  logic            i_mret,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_epc,
    output pc_sel_e         o_sel,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic tgt_misaligned;

    assign tgt_misaligned = (i_redirect_pc & ALIGN_MASK) != '0;

    always_comb begin
        o_sel      = SEL_HOLD;
        o_misalign = 1'b0;
        if (i_run) begin
            if (i_trap)
                o_sel = SEL_TRAP;
            else if (i_mret)
                o_sel = SEL_MRET;
            else if (i_redirect_valid && tgt_misaligned)
                o_sel = SEL_MISALIGN;
            else if (i_redirect_valid)
                o_sel = SEL_REDIRECT;
            else if (i_stall)
                o_sel = SEL_HOLD;
            else
                o_sel = SEL_SEQ;
            o_misalign = (o_sel == SEL_MISALIGN);
        end else if (i_halted && i_redirect_valid) begin
            // Debug set-PC: a bad target is flagged but never traps.
            if (tgt_misaligned)
                o_misalign = 1'b1;
            else
                o_sel = SEL_REDIRECT;
        end
    end

    always_comb begin
        o_next_pc = i_pc;
        unique case (o_sel)
            SEL_TRAP:     o_next_pc = TRAP_VEC;
            SEL_MISALIGN: o_next_pc = TRAP_VEC;
            SEL_MRET:     o_next_pc = i_epc;
            SEL_REDIRECT: o_next_pc = i_redirect_pc;
            SEL_SEQ:      o_next_pc = i_pc + XLEN'(INC);
            SEL_HOLD:     o_next_pc = i_pc;
            default:      o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: reset vector, redirects,
// trap entry/return, halt/resume control and a fetch counter.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              INC       = DEF_INC,
    parameter int              CNT_W     = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    input  logic             i_trap,
    input  logic             i_mret,
    input  logic             i_halt,
    input  logic             i_resume,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_epc,
    output logic             o_trap_taken,
    output logic             o_misalign,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic             trap_q, trap_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    pc_sel_e         sel;
    logic [XLEN-1:0] next_pc;
    logic            sel_misalign;
    logic            trap_entry;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .INC      (INC)
    ) u_next_sel (
        .i_run            (state_q == S_RUN),
        .i_halted         (state_q == S_HALT),
        .i_stall          (i_stall),
        .i_trap           (i_trap),
        .i_mret           (i_mret),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_pc             (pc_q),
        .i_epc            (epc_q),
        .o_sel            (sel),
        .o_next_pc        (next_pc),
        .o_misalign       (sel_misalign)
    );

    assign trap_entry = (sel == SEL_TRAP) || (sel == SEL_MISALIGN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (i_halt) state_d = S_HALT;
            S_HALT:  if (i_resume) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        pc_d     = next_pc;
        epc_d    = trap_entry ? pc_q : epc_q;
        trap_d   = trap_entry;
        mis_d    = sel_misalign;
        valid_d  = (state_d == S_RUN);
        halted_d = (state_d == S_HALT);
        cnt_d    = cnt_q;
        if (valid_q && !i_stall)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_VEC;
            epc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_epc        = epc_q;
    assign o_valid      = valid_q;
    assign o_halted     = halted_q;
    assign o_trap_taken = trap_q;
    assign o_misalign   = mis_q;
    assign o_fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: INC=4 and INC=2 instances on shared stimulus.
module tb_pc_gen_unit;

    localparam int MB = 0;
    localparam int MR = 1;
    localparam int MH = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        trap;
    logic        mret;
    logic        halt;
    logic        resume;

    logic [31:0] pc_o    [2];
    logic        valid_o [2];
    logic [31:0] epc_o   [2];
    logic        trap_o  [2];
    logic        mis_o   [2];
    logic        halt_o  [2];
    logic [3:0]  cnt_o   [2];

    int          errors = 0;
    int          checks = 0;

    logic [31:0] m_pc    [2];
    logic [31:0] m_epc   [2];
    bit          m_valid [2];
    bit          m_halted[2];
    bit          m_trap  [2];
    bit          m_mis   [2];
    int          m_cnt   [2];
    int          m_mode  [2];
    int          incs    [2] = '{4, 2};

    pc_gen_unit #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(4), .CNT_W(4)
    ) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect_valid(rv), .i_redirect_pc(rpc),
        .i_trap(trap), .i_mret(mret), .i_halt(halt), .i_resume(resume),
        .o_pc(pc_o[0]), .o_valid(valid_o[0]), .o_epc(epc_o[0]),
        .o_trap_taken(trap_o[0]), .o_misalign(mis_o[0]),
        .o_halted(halt_o[0]), .o_fetch_cnt(cnt_o[0])
    );

    pc_gen_unit #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(2), .CNT_W(4)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect_valid(rv), .i_redirect_pc(rpc),
        .i_trap(trap), .i_mret(mret), .i_halt(halt), .i_resume(resume),
        .o_pc(pc_o[1]), .o_valid(valid_o[1]), .o_epc(epc_o[1]),
        .o_trap_taken(trap_o[1]), .o_misalign(mis_o[1]),
        .o_halted(halt_o[1]), .o_fetch_cnt(cnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour, evaluated once per rising edge from sampled inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit odd;
            odd = (rpc % incs[k]) != 0;
            if (rst) begin
                m_pc[k] = 32'h0; m_epc[k] = 32'h0;
                m_valid[k] = 0; m_halted[k] = 0;
                m_trap[k] = 0; m_mis[k] = 0;
                m_cnt[k] = 0; m_mode[k] = MB;
            end else begin
                if (m_valid[k] && !stall) m_cnt[k] = (m_cnt[k] + 1) % 16;
                m_trap[k] = 0;
                m_mis[k]  = 0;
                if (m_mode[k] == MB) begin
                    m_mode[k] = MR;
                end else if (m_mode[k] == MR) begin
                    if (trap) begin
                        m_epc[k] = m_pc[k]; m_pc[k] = 32'h100; m_trap[k] = 1;
                    end else if (mret) begin
                        m_pc[k] = m_epc[k];
                    end else if (rv && odd) begin
                        m_epc[k] = m_pc[k]; m_pc[k] = 32'h100;
                        m_trap[k] = 1; m_mis[k] = 1;
                    end else if (rv) begin
                        m_pc[k] = rpc;
                    end else if (!stall) begin
                        m_pc[k] = m_pc[k] + incs[k];
                    end
                    if (halt) m_mode[k] = MH;
                end else begin
                    if (rv) begin
                        if (odd) m_mis[k] = 1;
                        else m_pc[k] = rpc;
                    end
                    if (resume) m_mode[k] = MR;
                end
                m_valid[k]  = (m_mode[k] == MR);
                m_halted[k] = (m_mode[k] == MH);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; rv = 0; rpc = 0;
        trap = 0; mret = 0; halt = 0; resume = 0;
    endtask

    task automatic boot_to(input int n);
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc_o[0] !== 32'h0 || valid_o[0] !== 1'b0 || epc_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: pc=%h valid=%b epc=%h want 0/0/0",
                     pc_o[0], valid_o[0], epc_o[0]);
        end
        checks++;
        if (trap_o[0] !== 0 || mis_o[0] !== 0 || halt_o[0] !== 0 || cnt_o[0] !== 0) begin
            errors++;
            $display("FAIL reset_flags: trap=%b mis=%b halt=%b cnt=%h want 0",
                     trap_o[0], mis_o[0], halt_o[0], cnt_o[0]);
        end
        rst = 0;
        tick();
        checks++;
        if (pc_o[0] !== 32'h0 || valid_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL boot_exit: pc=%h valid=%b want 0/1", pc_o[0], valid_o[0]);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc_o[0] !== 32'(4 * i) || valid_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL seq_%0d: pc=%h valid=%b want %h/1",
                         i, pc_o[0], valid_o[0], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_stall();
        boot_to(2);
        stall = 1; rv = 1; rpc = 32'h200;
        tick();
        checks++;
        if (pc_o[0] !== 32'h200) begin
            errors++;
            $display("FAIL redirect_over_stall: pc=%h want 200", pc_o[0]);
        end
        rv = 0;
        tick();
        tick();
        checks++;
        if (pc_o[0] !== 32'h200 || pc_o[1] !== 32'h200) begin
            errors++;
            $display("FAIL stall_hold: pc=%h/%h want 200", pc_o[0], pc_o[1]);
        end
        idle();
    endtask

    task automatic test_trap_mret();
        boot_to(4);
        trap = 1; rv = 1; rpc = 32'h200;
        tick();
        checks++;
        if (pc_o[0] !== 32'h100 || epc_o[0] !== 32'h10 || trap_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL trap_entry: pc=%h epc=%h pulse=%b want 100/10/1",
                     pc_o[0], epc_o[0], trap_o[0]);
        end
        idle();
        tick();
        checks++;
        if (trap_o[0] !== 1'b0 || pc_o[0] !== 32'h104) begin
            errors++;
            $display("FAIL trap_pulse_end: pulse=%b pc=%h want 0/104",
                     trap_o[0], pc_o[0]);
        end
        mret = 1;
        tick();
        checks++;
        if (pc_o[0] !== 32'h10) begin
            errors++;
            $display("FAIL mret: pc=%h want 10", pc_o[0]);
        end
        idle();
    endtask

    task automatic test_misalign();
        boot_to(8);
        rv = 1; rpc = 32'h202;
        tick();
        checks++;
        if (pc_o[0] !== 32'h100 || epc_o[0] !== 32'h20 ||
            mis_o[0] !== 1'b1 || trap_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL misalign_inc4: pc=%h epc=%h mis=%b trap=%b want 100/20/1/1",
                     pc_o[0], epc_o[0], mis_o[0], trap_o[0]);
        end
        checks++;
        if (pc_o[1] !== 32'h202 || mis_o[1] !== 1'b0 || trap_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL aligned_inc2: pc=%h mis=%b trap=%b want 202/0/0",
                     pc_o[1], mis_o[1], trap_o[1]);
        end
        idle();
        tick();
        checks++;
        if (mis_o[0] !== 1'b0 || trap_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse_end: mis=%b trap=%b want 0/0",
                     mis_o[0], trap_o[0]);
        end
    endtask

    task automatic test_halt();
        boot_to(16);
        halt = 1;
        tick();
        checks++;
        if (pc_o[0] !== 32'h44 || halt_o[0] !== 1'b1 || valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: pc=%h halted=%b valid=%b want 44/1/0",
                     pc_o[0], halt_o[0], valid_o[0]);
        end
        halt = 0; trap = 1; mret = 1;
        tick();
        checks++;
        if (pc_o[0] !== 32'h44 || trap_o[0] !== 1'b0 || epc_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL halt_ignore_trap: pc=%h trap=%b epc=%h want 44/0/0",
                     pc_o[0], trap_o[0], epc_o[0]);
        end
        trap = 0; mret = 0; rv = 1; rpc = 32'h80;
        tick();
        checks++;
        if (pc_o[0] !== 32'h80 || halt_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL halt_setpc: pc=%h halted=%b want 80/1", pc_o[0], halt_o[0]);
        end
        rpc = 32'h82;
        tick();
        checks++;
        if (pc_o[0] !== 32'h80 || mis_o[0] !== 1'b1 ||
            trap_o[0] !== 1'b0 || epc_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL halt_misalign: pc=%h mis=%b trap=%b epc=%h want 80/1/0/0",
                     pc_o[0], mis_o[0], trap_o[0], epc_o[0]);
        end
        rv = 0; halt = 1; resume = 1;
        tick();
        checks++;
        if (pc_o[0] !== 32'h80 || valid_o[0] !== 1'b1 || halt_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL resume: pc=%h valid=%b halted=%b want 80/1/0",
                     pc_o[0], valid_o[0], halt_o[0]);
        end
        idle();
        tick();
        checks++;
        if (pc_o[0] !== 32'h84) begin
            errors++;
            $display("FAIL post_resume: pc=%h want 84", pc_o[0]);
        end
    endtask

    task automatic test_wrap();
        boot_to(0);
        rv = 1; rpc = 32'hFFFF_FFFC;
        tick();
        rv = 0;
        tick();
        checks++;
        if (pc_o[0] !== 32'h0 || pc_o[1] !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h/%h want 0/fffffffe", pc_o[0], pc_o[1]);
        end
    endtask

    task automatic test_counter_reset();
        boot_to(0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) begin
                checks++;
                if (cnt_o[0] !== 4'(i)) begin
                    errors++;
                    $display("FAIL fetch_cnt_%0d: cnt=%h want %h", i, cnt_o[0], 4'(i));
                end
            end
        end
        trap = 1;
        tick();
        trap = 0; halt = 1;
        tick();
        rst = 1; trap = 1; rv = 1; rpc = 32'h202; resume = 1; stall = 1;
        tick();
        checks++;
        if (pc_o[0] !== 32'h0 || epc_o[0] !== 32'h0 || valid_o[0] !== 1'b0 ||
            trap_o[0] !== 1'b0 || mis_o[0] !== 1'b0 ||
            halt_o[0] !== 1'b0 || cnt_o[0] !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_halt: pc=%h epc=%h v=%b t=%b m=%b h=%b c=%h want all 0",
                     pc_o[0], epc_o[0], valid_o[0], trap_o[0], mis_o[0],
                     halt_o[0], cnt_o[0]);
        end
        idle();
    endtask

    task automatic test_random();
        boot_to(0);
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            rv     = ($urandom_range(0, 4) == 0);
            rpc    = ($urandom & 32'h0000_03FC) |
                     32'($urandom_range(0, 3) == 0 ? 2 : 0) |
                     32'($urandom_range(0, 7) == 0 ? 1 : 0);
            trap   = ($urandom_range(0, 19) == 0);
            mret   = ($urandom_range(0, 19) == 0);
            halt   = ($urandom_range(0, 19) == 0);
            resume = ($urandom_range(0, 4) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (pc_o[k] !== m_pc[k] || epc_o[k] !== m_epc[k]) begin
                    errors++;
                    $display("FAIL rand_pc[%0d] n=%0d: pc=%h epc=%h want %h/%h",
                             k, n, pc_o[k], epc_o[k], m_pc[k], m_epc[k]);
                end
                checks++;
                if (valid_o[k] !== m_valid[k] || halt_o[k] !== m_halted[k] ||
                    trap_o[k] !== m_trap[k] || mis_o[k] !== m_mis[k] ||
                    cnt_o[k] !== 4'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL rand_flags[%0d] n=%0d: v%b h%b t%b m%b c%h want v%b h%b t%b m%b c%h",
                             k, n, valid_o[k], halt_o[k], trap_o[k], mis_o[k], cnt_o[k],
                             m_valid[k], m_halted[k], m_trap[k], m_mis[k], 4'(m_cnt[k]));
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_redirect_stall();
        test_trap_mret();
        test_misalign();
        test_halt();
        test_wrap();
        test_counter_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
